// File: rtl/ram_access_unit.sv
// Initiator-side sequencer for the 256x32 single-port data RAM: single-word read,
// single-word write and ascending block copy, one response pulse per request.
module ram_access_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CP = 2'b10;

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(255);
  localparam logic [ADDR_W:0] ONE_X     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    WR,
    CP_RD,
    CP_CAP,
    CP_WR,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_wr_q, ram_wr_d;
  logic                ram_rd_q, ram_rd_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  // Sums are one bit wider than the address so ranges running past word 255
  // cannot wrap back into the backed region.
  function automatic logic req_is_bad(input logic [1:0]        op,
                                      input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] dst,
                                      input logic [ADDR_W-1:0] len);
    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic            bad;
    src_end = {1'b0, addr} + {1'b0, len} - ONE_X;
    dst_end = {1'b0, dst} + {1'b0, len} - ONE_X;
    case (op)
      OP_RD, OP_WR: bad = ({1'b0, addr} > LAST_WORD);
      OP_CP:        bad = (len == '0) || (src_end > LAST_WORD) || (dst_end > LAST_WORD);
      default:      bad = 1'b1;
    endcase
    req_is_bad = bad;
  endfunction

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ram_addr_d  = '0;
    ram_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_is_bad(req_op, req_addr, req_dst, req_len)) begin
            state_d = ERR;
          end else begin
            case (req_op)
              OP_RD: begin
                state_d    = RD;
                ram_rd_d   = 1'b1;
                ram_addr_d = req_addr;
              end
              OP_WR: begin
                state_d     = WR;
                ram_wr_d    = 1'b1;
                ram_addr_d  = req_addr;
                ram_wdata_d = req_wdata;
              end
              default: begin
                state_d    = CP_RD;
                src_d      = req_addr;
                dst_d      = req_dst;
                len_d      = req_len;
                idx_d      = '0;
                ram_rd_d   = 1'b1;
                ram_addr_d = req_addr;
              end
            endcase
          end
        end
      end
      RD: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rsp_rdata_d = ram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      CP_RD: begin
        state_d = CP_CAP;
      end
      // The write-data register doubles as the copy buffer: the captured word
      // is presented on ram_wdata during the following CP_WR cycle.
      CP_CAP: begin
        state_d     = CP_WR;
        ram_wr_d    = 1'b1;
        ram_addr_d  = dst_q + idx_q;
        ram_wdata_d = ram_rdata;
      end
      CP_WR: begin
        if (idx_q == len_q - ONE) begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          idx_d      = idx_q + ONE;
          state_d    = CP_RD;
          ram_rd_d   = 1'b1;
          ram_addr_d = src_q + idx_q + ONE;
        end
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_rd_q    <= ram_rd_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// Scoreboard bench for ram_access_unit: directed and random requests against a
// word-level model, with a behavioural 256x32 registered-read RAM attached.
module tb_ram_access_unit;

  logic        clock;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [8:0]  req_addr;
  logic [8:0]  req_dst;
  logic [8:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [8:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic        ram_rd;
  logic [31:0] ram_rdata;

  ram_access_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_dst   (req_dst),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_wdata (ram_wdata),
    .ram_rd    (ram_rd),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: data appears the cycle after ram_rd, junk otherwise.
  logic [31:0] ram_mem [256];
  logic [31:0] ram_q;
  logic        rd_pend;
  always @(posedge clock) begin
    if (ram_wr && !ram_addr[8]) ram_mem[ram_addr[7:0]] <= ram_wdata;
    rd_pend <= ram_rd;
    ram_q   <= ram_mem[ram_addr[7:0]];
  end
  assign ram_rdata = rd_pend ? ram_q : 32'hBAD0_BAD0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor-side counters
  int c_total = 0;
  int c_pass  = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int overlap_n = 0;
  exp_t mon_e;

  always @(negedge clock) begin
    if (ram_wr && ram_rd) overlap_n <= overlap_n + 1;
    if (ram_wr) wr_seen <= wr_seen + 1;
    if (ram_rd) rd_seen <= rd_seen + 1;
    if (req_ready || (rsp_err && !rsp_valid)) begin
      c_total = c_total + 1;
      if (ram_wr || ram_rd || ram_addr != 9'd0 || ram_wdata != 32'd0 || (rsp_err && !rsp_valid))
        $display("FAIL idle_bus cyc=%0d wr=%0b rd=%0b addr=%h wdata=%h err=%0b required all zero",
                 cyc, ram_wr, ram_rd, ram_addr, ram_wdata, rsp_err && !rsp_valid);
      else
        c_pass = c_pass + 1;
    end
    if (rsp_valid) begin
      c_total = c_total + 1;
      if (sb.size() == 0) begin
        $display("FAIL spurious_rsp cyc=%0d err=%0b required no response", cyc, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata || cyc != mon_e.cyc)
          $display("FAIL rsp err=%0b rdata=%h cyc=%0d required err=%0b rdata=%h cyc=%0d",
                   rsp_err, rsp_rdata, cyc, mon_e.err, mon_e.rdata, mon_e.cyc);
        else
          c_pass = c_pass + 1;
      end
    end
  end

  // Main-process state: reference memory and counters
  logic [31:0] ref_mem [256];
  logic [31:0] model_rdata = 32'd0;
  int m_total = 0;
  int m_pass  = 0;
  int exp_wr  = 0;
  int exp_rd  = 0;
  bit prev_keep = 1'b0;
  int prev_acc  = 0;
  int prev_lat  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    m_total++;
    if (act === req) m_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic model(input logic [1:0] op, input int a, input int d, input int l,
                       input logic [31:0] wd, input int acc, output int lat);
    exp_t e;
    logic bad;
    case (op)
      2'b00, 2'b01: bad = (a > 255);
      2'b10:        bad = (l == 0) || (a + l - 1 > 255) || (d + l - 1 > 255);
      default:      bad = 1'b1;
    endcase
    lat = 1;
    if (!bad) begin
      if (op == 2'b00) begin
        model_rdata = ref_mem[a];
        lat = 2;
        exp_rd++;
      end else if (op == 2'b01) begin
        ref_mem[a] = wd;
        exp_wr++;
      end else begin
        for (int k = 0; k < l; k++) ref_mem[d + k] = ref_mem[a + k];
        lat = 3 * l;
        exp_rd += l;
        exp_wr += l;
      end
    end
    e.err   = bad;
    e.rdata = model_rdata;
    e.cyc   = acc + lat;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [1:0] op, input int a, input int d, input int l,
                        input logic [31:0] wd, input bit keep);
    int acc;
    int lat;
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = 9'(a);
    req_dst   = 9'(d);
    req_len   = 9'(l);
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      m_total++;
      $display("FAIL accept_timeout ready=%0b required=1", req_ready);
      req_valid = 1'b0;
      prev_keep = 1'b0;
      return;
    end
    acc = cyc + 1;
    model(op, a, d, l, wd, acc, lat);
    if (prev_keep) chk("accept_cadence", 64'(acc), 64'(prev_acc + prev_lat + 1));
    prev_keep = keep;
    prev_acc  = acc;
    prev_lat  = lat;
    @(posedge clock);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic end_burst();
    req_valid = 1'b0;
    prev_keep = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    m_total++;
    if (sb.size() == 0) m_pass++;
    else $display("FAIL drain pending=%0d required=0", sb.size());
  endtask

  initial begin
    logic [31:0] pre [4];
    logic [1:0]  op;
    int acc;
    int r;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 9'd0;
    req_dst   = 9'd0;
    req_len   = 9'd0;
    req_wdata = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ram_wr",    64'(ram_wr),    64'd0);
    chk("rst_ram_rd",    64'(ram_rd),    64'd0);
    chk("rst_ram_addr",  64'(ram_addr),  64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    rst_n = 1'b1;

    // Preload every word with back-to-back writes
    for (int a = 0; a < 256; a++) do_req(2'b01, a, 0, 0, $urandom, 1'b1);
    end_burst();
    drain();

    // Directed cases
    do_req(2'b01, 0,   0,  0, 32'h2245_0000, 1'b0);
    do_req(2'b00, 0,   0,  0, 32'd0,         1'b0);
    do_req(2'b01, 1,   0,  0, 32'h10F0_0010, 1'b0);
    do_req(2'b01, 255, 0,  0, 32'hDEAD_BEEF, 1'b0);
    do_req(2'b00, 1,   0,  0, 32'd0,         1'b0);
    do_req(2'b00, 255, 0,  0, 32'd0,         1'b0);
    do_req(2'b10, 0,   16, 2, 32'd0,         1'b0);
    do_req(2'b00, 16,  0,  0, 32'd0,         1'b0);
    do_req(2'b00, 17,  0,  0, 32'd0,         1'b0);
    do_req(2'b00, 256, 0,  0, 32'd0,         1'b0);
    do_req(2'b10, 0,   32, 0, 32'd0,         1'b0);
    do_req(2'b10, 254, 0,  3, 32'd0,         1'b0);
    do_req(2'b11, 5,   0,  0, 32'd0,         1'b0);
    do_req(2'b10, 10,  11, 4, 32'd0,         1'b0);
    drain();

    // Back-to-back alternating write/read with req_valid held
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 255);
      do_req(2'b01, r, 0, 0, $urandom, 1'b1);
      do_req(2'b00, r, 0, 0, 32'd0,    1'b1);
    end
    end_burst();
    drain();

    // Reset lands in the write cycle of word 2, after words 0 and 1 are committed
    for (int k = 0; k < 4; k++) pre[k] = ref_mem[8'h80 + k];
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 9'h040;
    req_dst   = 9'h080;
    req_len   = 9'd4;
    chk("rstcp_ready_before", 64'(req_ready), 64'd1);
    acc = cyc + 1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstcp_ram_wr",    64'(ram_wr),    64'd0);
    chk("rstcp_ram_rd",    64'(ram_rd),    64'd0);
    chk("rstcp_ram_addr",  64'(ram_addr),  64'd0);
    chk("rstcp_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rstcp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstcp_req_ready", 64'(req_ready), 64'd1);
    chk("rstcp_cycle",     64'(cyc),       64'(acc + 8));
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstcp_ready_after", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k < 2) ref_mem[8'h80 + k] = ref_mem[8'h40 + k];
      chk("rstcp_dst_word", 64'(ram_mem[8'h80 + k]), 64'(k < 2 ? ref_mem[8'h40 + k] : pre[k]));
    end
    exp_rd += 3;
    exp_wr += 2;
    model_rdata = 32'd0;

    // Random mix, including out-of-range and reserved requests
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_req(op, $urandom_range(0, 271), $urandom_range(0, 271), $urandom_range(0, 8),
             $urandom, ($urandom_range(0, 1) == 1));
    end
    end_burst();
    drain();

    chk("strobe_overlap", 64'(overlap_n), 64'd0);
    chk("ram_wr_cycles",  64'(wr_seen),   64'(exp_wr));
    chk("ram_rd_cycles",  64'(rd_seen),   64'(exp_rd));
    for (int a = 0; a < 256; a++) chk("final_mem", 64'(ram_mem[a]), 64'(ref_mem[a]));

    $display("%0d/%0d checks passed", m_pass + c_pass, m_total + c_total);
    $finish;
  end

endmodule
